// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer: walks the RGB LED around a six-phase colour wheel.
// Each channel is driven by a registered PWM comparator. A debounced push-button
// toggles between running the wheel and holding the current colour.
// Optional build macro: RGB_GAMMA_EN squares each channel level before it reaches
// the PWM comparator, which gives a more even perceived brightness ramp.
// The red/green/blue outputs are active-high. The top level inverts them for the
// active-low LED pads.

module rgb_hue_sequencer #(
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned STEP_CYCLES     = 46875,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [2:0] phase,
    output logic       holding
);

    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PWM_BITS-1:0] Max      = {PWM_BITS{1'b1}};
    localparam logic [StepW-1:0]    StepLast = StepW'(STEP_CYCLES - 1);
    localparam logic [DbW-1:0]      DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StRun,
        StHold
    } state_e;

    // Button path
    logic           sync1_q, sync2_q;
    logic           stable_q, stable_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           press_pulse;

    // Sequencer state
    state_e              state_q, state_d;
    logic                holding_q;
    logic [StepW-1:0]    step_q, step_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d;
    logic [2:0]          phase_q, phase_d;

    // Channel levels and PWM
    logic [PWM_BITS-1:0] red_lvl, green_lvl, blue_lvl;
    logic [PWM_BITS-1:0] red_eff, green_eff, blue_eff;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                red_q, green_q, blue_q;

    // Two-flop synchroniser. It resets to the idle (released) button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d    = stable_q;
        db_cnt_d    = db_cnt_q;
        press_pulse = 1'b0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DbLast) begin
                stable_d    = sync2_q;
                db_cnt_d    = '0;
                // Only a 1->0 transition (a press) produces a pulse. A release does not.
                press_pulse = stable_q & ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Run/hold toggle on each accepted press.
    always_comb begin
        state_d = state_q;
        if (press_pulse) begin
            state_d = (state_q == StRun) ? StHold : StRun;
        end
    end

    // FSM state register. The holding flag is registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            holding_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            holding_q <= (state_d == StHold);
        end
    end

    // Step counter, ramp and phase advance only while running.
    // A tick that coincides with a press still lands, because the decision uses state_q.
    always_comb begin
        step_d  = step_q;
        ramp_d  = ramp_q;
        phase_d = phase_q;
        if (state_q == StRun) begin
            if (step_q == StepLast) begin
                step_d = '0;
                if (ramp_q != Max) begin
                    ramp_d = ramp_q + PWM_BITS'(1);
                end else begin
                    ramp_d  = '0;
                    phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
                end
            end else begin
                step_d = step_q + StepW'(1);
            end
        end
    end

    // Wheel position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            ramp_q  <= '0;
            phase_q <= '0;
        end else begin
            step_q  <= step_d;
            ramp_q  <= ramp_d;
            phase_q <= phase_d;
        end
    end

    // Colour wheel: one channel ramps up or down while the other two sit at MAX or 0.
    always_comb begin
        red_lvl   = '0;
        green_lvl = '0;
        blue_lvl  = '0;
        unique case (phase_q)
            3'd0: begin
                red_lvl   = Max;
                green_lvl = ramp_q;
            end
            3'd1: begin
                red_lvl   = Max - ramp_q;
                green_lvl = Max;
            end
            3'd2: begin
                green_lvl = Max;
                blue_lvl  = ramp_q;
            end
            3'd3: begin
                green_lvl = Max - ramp_q;
                blue_lvl  = Max;
            end
            3'd4: begin
                red_lvl   = ramp_q;
                blue_lvl  = Max;
            end
            3'd5: begin
                red_lvl   = Max;
                blue_lvl  = Max - ramp_q;
            end
            default: begin
                red_lvl   = '0;
                green_lvl = '0;
                blue_lvl  = '0;
            end
        endcase
    end

`ifdef RGB_GAMMA_EN
    // Square-law correction: (l*l) >> PWM_BITS, taken from the upper half of the full product.
    function automatic logic [PWM_BITS-1:0] gamma_corr(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] prod;
        prod = (2 * PWM_BITS)'(lvl) * (2 * PWM_BITS)'(lvl);
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    assign red_eff   = gamma_corr(red_lvl);
    assign green_eff = gamma_corr(green_lvl);
    assign blue_eff  = gamma_corr(blue_lvl);
`else
    assign red_eff   = red_lvl;
    assign green_eff = green_lvl;
    assign blue_eff  = blue_lvl;
`endif

    // Free-running PWM counter. It keeps counting in HOLD so the held colour stays lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // Registered comparators. Level 0 gives a constant 0; MAX is high for MAX of MAX+1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q   <= 1'b0;
            green_q <= 1'b0;
            blue_q  <= 1'b0;
        end else begin
            red_q   <= (pwm_cnt_q < red_eff);
            green_q <= (pwm_cnt_q < green_eff);
            blue_q  <= (pwm_cnt_q < blue_eff);
        end
    end

    assign red     = red_q;
    assign green   = green_q;
    assign blue    = blue_q;
    assign phase   = phase_q;
    assign holding = holding_q;

endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
Sequences the on-board RGB LED around a 6-phase colour wheel using per-channel PWM.
- Produces active-high red/green/blue drive. The top level inverts these for the active-low LED pads.
- A debounced push-button toggles between running and holding the current colour.
- Sits between the raw board button input and the LED output inverters in the top level.

Parameters:
PWM_BITS, 8, width of PWM counter, ramp value and channel levels (MAX = 2^PWM_BITS-1)
STEP_CYCLES, 46875, clk cycles per ramp increment (≈6 s full wheel at 12 MHz, PWM_BITS=8)
DEBOUNCE_CYCLES, 120000, consecutive stable clk cycles required to accept a button change (10 ms at 12 MHz)

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  asynchronous, active-high reset
btn_n  input  1  raw push-button, active-low, asynchronous to clk
red  output  1  red channel PWM drive, active-high, registered
green  output  1  green channel PWM drive, active-high, registered
blue  output  1  blue channel PWM drive, active-high, registered
phase  output  3  current wheel phase, 0..5
holding  output  1  1 = HOLD state (colour frozen)

Behaviour:
- Reset (async, rst=1): red/green/blue=0, phase=0, holding=0, state=RUN, ramp=0, step counter=0, pwm_cnt=0, both synchroniser FFs=1, stable button=1, debounce counter=0.
- Button path:
  - 2-FF synchroniser on btn_n.
  - If the synced value differs from stable, the debounce counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - If the synced value equals stable, the counter clears.
  - Press = stable 1→0: a one-cycle internal pulse. Release generates nothing.
- FSM states: RUN, HOLD.
  - Press pulse in RUN → HOLD on the next edge.
  - Press pulse in HOLD → RUN on the next edge.
  - holding = (state==HOLD), registered.
- Step counter: 0..STEP_CYCLES-1.
  - Increments only in RUN. Tick = (counter==STEP_CYCLES-1), and the counter wraps to 0 on tick.
  - On tick: if ramp<MAX, ramp+1. Otherwise ramp=0 and phase advances, 5 wraps to 0.
  - Each ramp value lasts STEP_CYCLES cycles. Each phase lasts (MAX+1)*STEP_CYCLES cycles.
- Press pulse coincident with tick: the tick is applied in that cycle; the state change takes effect next cycle.
- HOLD freezes step counter, ramp and phase. PWM continues, so the colour stays lit.
- Channel levels, combinational from phase and ramp r:
  - phase 0: R=MAX, G=r, B=0
  - phase 1: R=MAX-r, G=MAX, B=0
  - phase 2: R=0, G=MAX, B=r
  - phase 3: R=0, G=MAX-r, B=MAX
  - phase 4: R=r, G=0, B=MAX
  - phase 5: R=MAX, G=0, B=MAX-r
- PWM: pwm_cnt is a free-running PWM_BITS counter that wraps MAX→0 and is unaffected by state. Each output is registered: out(t+1) = (pwm_cnt(t) < level(t)).
  - Level 0 → constantly 0.
  - Level MAX → high MAX of every MAX+1 cycles.
  - Latency from level change to output: 1 cycle.
- Mid-operation reset returns everything to reset values immediately. There is no output glitch beyond async clear to 0.

Optional Feature:
- Macro: RGB_GAMMA_EN.
- Defined: each channel level is passed through a perceptual correction, level_eff = (level*level) >> PWM_BITS, using a 2*PWM_BITS-bit product truncated to PWM_BITS bits. level_eff feeds the PWM comparator, so 0→0 and MAX→MAX-1.
- Undefined: level_eff = level. There is no multiplier, and the correction logic is not present.
- Phase, ramp, FSM and latency are identical in both builds.

Test Plan:
(All scenarios: PWM_BITS=3, STEP_CYCLES=2, DEBOUNCE_CYCLES=4, gamma disabled unless stated.)
- Reset release, btn_n=1, observe 8 cycles: red high 7 of 8 cycles, green 0 for the first 2 cycles then high 1 of 8, blue always 0. phase=0, holding=0.
- Run 16 cycles from reset: phase=1, ramp=0. After 96 cycles phase=0 again, with the phase sequence 0,1,2,3,4,5.
- btn_n low for 10 cycles: after 2 sync + 4 debounce cycles, exactly one press pulse and holding=1. Phase/ramp stay constant for 200 cycles while PWM keeps toggling. Second press → holding=0 and ramp resumes from the held value.
- Glitch: btn_n low for 3 cycles then high → no state change, holding stays 0.
- Assert rst for 1 cycle mid-phase 3 during HOLD: outputs 0 immediately. After release phase=0, holding=0, RUN.
- With RGB_GAMMA_EN, phase 0, r=4: green level_eff = 16>>3 = 2, so green is high 2 of 8 cycles; red is high 6 of 8 (level_eff=49>>3=6).
